// File: rtl/edac_scrubber.sv
// edac_scrubber: background scrubber for the triple-redundant EDAC memory.
// It walks the address space one location per pass, reads each location
// through the voter, and writes the voted byte back when the copies disagree.
//
// Bus ownership handshake: the scrubber may take the bus (SGNT=1) only from
// the cycle after it samples CPU_BUSY=0 in arbitration. If it samples
// CPU_BUSY=1 in any bus cycle, it drops SGNT and all strobes on the next
// clock. The pass then restarts at the same address, and nothing is counted
// for the aborted pass.
module edac_scrubber #(
  parameter int ADDR_BITS     = 15,
  parameter int INTERVAL_BITS = 12,
  parameter int COUNT_BITS    = 8
) (
  input  logic                     CLK,
  input  logic                     nRESET,
  input  logic                     EN,
  input  logic [INTERVAL_BITS-1:0] INTERVAL,
  input  logic                     CPU_BUSY,
  input  logic [7:0]               EDI,
  input  logic                     ERR_DET,
  input  logic                     CLR_COUNT,
  output logic                     SGNT,
  output logic [ADDR_BITS-1:0]     SA,
  output logic                     nSRD,
  output logic                     nSWR,
  output logic [7:0]               SD,
  output logic                     SDRIVE,
  output logic                     FIX_PULSE,
  output logic                     WRAP,
  output logic [COUNT_BITS-1:0]    FIX_COUNT,
  output logic [3:0]               DBG_STATE
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_ARB  = 4'd1,
    S_RD1  = 4'd2,
    S_RD2  = 4'd3,
    S_RD3  = 4'd4,
    S_WR1  = 4'd5,
    S_WR2  = 4'd6,
    S_WR3  = 4'd7,
    S_DONE = 4'd8
  } state_t;

  state_t                   state;
  state_t                   nxt;
  logic [INTERVAL_BITS-1:0] timer;
  logic                     done_now;
  logic                     fix_now;
  logic                     nxt_on_bus;
  logic                     nxt_writing;

  assign DBG_STATE = state;

  // Next-state decode: a CPU access in any bus cycle aborts back to arbitration
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (timer == '0 && EN) nxt = S_ARB;
      S_ARB: begin
        if (!EN)            nxt = S_IDLE;
        else if (!CPU_BUSY) nxt = S_RD1;
      end
      S_RD1:   nxt = CPU_BUSY ? S_ARB : S_RD2;
      S_RD2:   nxt = CPU_BUSY ? S_ARB : S_RD3;
      S_RD3:   nxt = CPU_BUSY ? S_ARB : (ERR_DET ? S_WR1 : S_DONE);
      S_WR1:   nxt = CPU_BUSY ? S_ARB : S_WR2;
      S_WR2:   nxt = CPU_BUSY ? S_ARB : S_WR3;
      S_WR3:   nxt = CPU_BUSY ? S_ARB : S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  assign done_now    = (nxt == S_DONE) && (state != S_DONE);
  assign fix_now     = (state == S_WR3) && (nxt == S_DONE);
  assign nxt_on_bus  = (nxt == S_RD1) || (nxt == S_RD2) || (nxt == S_RD3) ||
                       (nxt == S_WR1) || (nxt == S_WR2) || (nxt == S_WR3);
  assign nxt_writing = (nxt == S_WR1) || (nxt == S_WR2) || (nxt == S_WR3);

  // State register and outputs decoded from the next state, so every output is a flop
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state     <= S_IDLE;
      timer     <= '0;
      SA        <= '0;
      SD        <= '0;
      FIX_COUNT <= '0;
      SGNT      <= 1'b0;
      nSRD      <= 1'b1;
      nSWR      <= 1'b1;
      SDRIVE    <= 1'b0;
      FIX_PULSE <= 1'b0;
      WRAP      <= 1'b0;
    end else begin
      state     <= nxt;
      SGNT      <= nxt_on_bus;
      nSRD      <= !((nxt == S_RD2) || (nxt == S_RD3));
      nSWR      <= (nxt != S_WR2);
      SDRIVE    <= nxt_writing;
      FIX_PULSE <= fix_now;
      WRAP      <= done_now && (&SA);

      // Voted data is latched only on a completed read, so an abort keeps the old value
      if (state == S_RD3 && nxt != S_ARB) SD <= EDI;

      // The address advances and the gap timer reloads only when a pass completes
      if (done_now) begin
        SA    <= SA + ADDR_BITS'(1);
        timer <= INTERVAL;
      end else if (state == S_IDLE && timer != '0) begin
        timer <= timer - INTERVAL_BITS'(1);
      end

      // Clear takes effect first, so a correction in the same cycle leaves a count of one
      if (CLR_COUNT)
        FIX_COUNT <= fix_now ? COUNT_BITS'(1) : '0;
      else if (fix_now && !(&FIX_COUNT))
        FIX_COUNT <= FIX_COUNT + COUNT_BITS'(1);
    end
  end

endmodule
